// File: rtl/spi_dac_pkg.sv
//----------------------------------------------------------------------------
// Module  : spi_dac_pkg
// Brief   : Shared types and constants for the SPI DAC command receiver.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package spi_dac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_e;

    localparam int          FRAME_BITS       = 32;
    localparam logic [5:0]  FRAME_CNT        = 6'(FRAME_BITS);
    localparam logic [5:0]  CNT_MAX          = 6'd63;
    localparam logic [3:0]  CMD_SETUP_REF    = 4'h8;
    localparam logic [3:0]  CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0]  ADDR_ALL         = 4'hF;

endpackage

`default_nettype wire

// File: rtl/spi_sync2.sv
//----------------------------------------------------------------------------
// Module  : spi_sync2
// Brief   : Two-flop synchronizer with a configurable reset value.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_dac_rx.sv
//----------------------------------------------------------------------------
// Module  : spi_dac_rx
// Brief   : SPI slave that decodes 32-bit DAC command frames (ref enable and
//           write/update of one channel). Optional stats: SPI_DAC_RX_STATS_EN.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'h0
) (
    input  logic        clk100mhz,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [3:0]  rx_cmd,
    output logic [3:0]  rx_addr,
    output logic [11:0] rx_data,
    output logic        ref_en,
    output logic [11:0] dac_code,
`ifdef SPI_DAC_RX_STATS_EN
    output logic        dac_update,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`else
    output logic        dac_update
`endif
);

    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    spi_sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk (clk100mhz),
        .rst (rst),
        .i_d (cs),
        .o_q (cs_s)
    );

    spi_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk (clk100mhz),
        .rst (rst),
        .i_d (sclk),
        .o_q (sclk_s)
    );

    spi_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk100mhz),
        .rst (rst),
        .i_d (mosi),
        .o_q (mosi_s)
    );

    state_e      state_q,       state_d;
    logic        cs_prev_q,     cs_prev_d;
    logic        sclk_prev_q,   sclk_prev_d;
    logic [1:0]  settle_q,      settle_d;
    logic        armed_q,       armed_d;
    logic [5:0]  cnt_q,         cnt_d;
    logic [31:0] sr_q,          sr_d;
    logic [3:0]  rx_cmd_q,      rx_cmd_d;
    logic [3:0]  rx_addr_q,     rx_addr_d;
    logic [11:0] rx_data_q,     rx_data_d;
    logic        ref_en_q,      ref_en_d;
    logic [11:0] dac_code_q,    dac_code_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q,   frame_err_d;
    logic        dac_update_q,  dac_update_d;
`ifdef SPI_DAC_RX_STATS_EN
    logic [15:0] frame_cnt_q,   frame_cnt_d;
    logic [15:0] err_cnt_q,     err_cnt_d;
`endif

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_fall;

    // The cs synchronizer powers up high, so a falling edge is only trusted
    // once a genuine high level on cs has made it through both flops.
    assign w_cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign w_cs_rise   = ~cs_prev_q & cs_s;
    assign w_sclk_fall = sclk_prev_q & ~sclk_s;

    always_comb begin
        state_d       = state_q;
        cs_prev_d     = cs_s;
        sclk_prev_d   = sclk_s;
        settle_d      = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d       = armed_q | ((settle_q == 2'd2) & cs_s);
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        rx_cmd_d      = rx_cmd_q;
        rx_addr_d     = rx_addr_q;
        rx_data_d     = rx_data_q;
        ref_en_d      = ref_en_q;
        dac_code_d    = dac_code_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        dac_update_d  = 1'b0;
`ifdef SPI_DAC_RX_STATS_EN
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = 6'd0;
                end
            end
            SHIFT: begin
                if (w_sclk_fall) begin
                    sr_d  = (sr_q << 1) | {31'd0, mosi_s};
                    cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;
                end
                // Decode from the next-state values so a final sclk edge
                // coinciding with cs rising is counted; pulses land in DECODE.
                if (w_cs_rise) begin
                    state_d = DECODE;
                    if (cnt_d == FRAME_CNT) begin
                        frame_valid_d = 1'b1;
                        rx_cmd_d      = sr_d[27:24];
                        rx_addr_d     = sr_d[23:20];
                        rx_data_d     = sr_d[19:8];
                        if (sr_d[27:24] == CMD_SETUP_REF) begin
                            ref_en_d = sr_d[0];
                        end
                        if ((sr_d[27:24] == CMD_WRITE_UPDATE) &&
                            ((sr_d[23:20] == CHANNEL) || (sr_d[23:20] == ADDR_ALL))) begin
                            dac_code_d   = sr_d[19:8];
                            dac_update_d = 1'b1;
                        end
`ifdef SPI_DAC_RX_STATS_EN
                        frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
`ifdef SPI_DAC_RX_STATS_EN
                        err_cnt_d   = err_cnt_q + 16'd1;
`endif
                    end
                end
            end
            DECODE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q       <= IDLE;
            cs_prev_q     <= 1'b1;
            sclk_prev_q   <= 1'b0;
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
            cnt_q         <= 6'd0;
            sr_q          <= 32'd0;
            rx_cmd_q      <= 4'd0;
            rx_addr_q     <= 4'd0;
            rx_data_q     <= 12'd0;
            ref_en_q      <= 1'b0;
            dac_code_q    <= 12'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            dac_update_q  <= 1'b0;
`ifdef SPI_DAC_RX_STATS_EN
            frame_cnt_q   <= 16'd0;
            err_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            cs_prev_q     <= cs_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            rx_cmd_q      <= rx_cmd_d;
            rx_addr_q     <= rx_addr_d;
            rx_data_q     <= rx_data_d;
            ref_en_q      <= ref_en_d;
            dac_code_q    <= dac_code_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            dac_update_q  <= dac_update_d;
`ifdef SPI_DAC_RX_STATS_EN
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign rx_cmd      = rx_cmd_q;
    assign rx_addr     = rx_addr_q;
    assign rx_data     = rx_data_q;
    assign ref_en      = ref_en_q;
    assign dac_code    = dac_code_q;
    assign dac_update  = dac_update_q;
`ifdef SPI_DAC_RX_STATS_EN
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;
`endif

endmodule

`default_nettype wire
